instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- PC-owning fetch front end for the 10-bit single-cycle CPU; the initiator side of the instruction ROM interface.
- Drives the ROM address, takes back the 10-bit instruction word and presents it to the decoder.
- Computes the next PC from decoder control (sequential, beq-taken, jump, halt, stall).
- Owns run/halt sequencing and a retired-instruction counter used by the bench.

Parameters:
- ADDR_W, 10, ROM address / PC width.
- INSTR_W, 10, instruction word width.
- OFF_W, 4, signed branch offset width (two's complement).
- JMP_W, 6, absolute jump target width (zero-extended to ADDR_W).
- RESET_PC, 0, first fetch address after start.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin or restart execution at RESET_PC.
- rom_addr  out  ADDR_W  ROM address; equals pc.
- rom_data  in  INSTR_W  ROM read data; combinational response to rom_addr.
- instr  out  INSTR_W  instruction to decoder; rom_data in RUN, else NOP (all zeros).
- instr_valid  out  1  high only in RUN.
- stall  in  1  hold the current instruction (load/store wait).
- halt  in  1  decoded halt.
- jump  in  1  decoded jump.
- jump_target  in  JMP_W  absolute target.
- branch  in  1  decoded beq.
- branch_eq  in  1  comparison result from register file.
- branch_off  in  OFF_W  signed offset.
- pc  out  ADDR_W  current PC.
- halted  out  1  high in HALTED.
- retired  out  CNT_W  count of instructions completed since start.

Behaviour:
- Reset (rst_n=0 at an edge) applies in any state, including mid-run:
  - state IDLE, pc=RESET_PC, retired=0, halted=0, instr_valid=0, instr=0.
- States: IDLE, RUN, HALTED.
  - IDLE: start=1 -> RUN; pc=RESET_PC, retired=0.
  - RUN: pc updates every edge per the priority list below.
  - HALTED: pc frozen at the halt address; start=1 -> RUN with pc=RESET_PC, retired=0.
  - start is ignored while in RUN.
- Decoder inputs are combinational from instr in the same cycle; they are sampled only in RUN.
- Next-PC priority in RUN (highest first):
  1. stall: pc, state and retired all hold; the same instr is re-presented.
  2. halt: go to HALTED, pc holds, retired+1.
  3. jump: pc = zero-extended jump_target, retired+1.
  4. branch & branch_eq: pc = pc + sign-extended branch_off, retired+1. The offset is relative to the branch's own address (beq at 4 with offset +2 -> pc 6).
  5. Otherwise: pc = pc + 1, retired+1.
- jump and branch together: jump wins.
- branch with branch_eq=0: pc+1.
- All PC arithmetic is modulo 2^ADDR_W: 1023+1 -> 0; pc 1 with offset -3 -> 1022.
- retired saturates at 2^CNT_W-1.
- rom_addr = pc at all times, including IDLE and HALTED.
- Latency: the first valid instr appears in the cycle after start is sampled; one instruction per cycle after that, with no bubbles on taken branches or jumps.
- halted = (state==HALTED), registered.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, INSTR_W, OFF_W, JMP_W
  - NOP_INSTR = 10'b0
  - fetch state enum {IDLE, RUN, HALTED}
- One natural combinational sub-module, ifu_next_pc. It takes pc, the control inputs, jump_target and branch_off, and returns the next pc. The priority and wrap logic live there so they can be unit-checked on their own.

Test Plan:
- Reset, then start with a ROM holding sequential non-control words -> pc sequence 0,1,2,3 on successive cycles; instr_valid=1 from the first RUN cycle; retired=3 after 3 cycles.
- pc=4, branch=1, branch_eq=1, branch_off=+2 -> next pc=6. Same cycle with branch_eq=0 -> next pc=5.
- pc=5, jump=1, jump_target=7 -> next pc=7. jump=1 and taken branch off=+2 at pc=20, target=15 -> next pc=15.
- Halt at pc=26 -> halted=1, pc stays 26, instr=0, instr_valid=0, retired frozen. Then start -> pc=0, retired=0.
- stall held 3 cycles at pc=12 -> pc=12 and retired unchanged for 3 cycles, instr stable; the release cycle advances to 13. Separately, pc=1023 sequential -> 0, and pc=1 with off=-3 -> 1022.
- rst_n=0 mid-run at pc=18 -> next edge gives state IDLE, pc=0, retired=0, instr_valid=0. start while in RUN is ignored (pc continues to increment).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, NOP encoding and fetch state type for the 10-bit CPU.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 10;
    localparam int unsigned OFF_W   = 4;
    localparam int unsigned JMP_W   = 6;

    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: ROM address/data plus the decoder control returned for the presented instruction.
interface instr_fetch_unit_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               stall;
    logic               halt;
    logic               jump;
    logic [JMP_W-1:0]   jump_target;
    logic               branch;
    logic               branch_eq;
    logic [OFF_W-1:0]   branch_off;

    modport master (
        output rom_addr, instr, instr_valid,
        input  rom_data, stall, halt, jump, jump_target, branch, branch_eq, branch_off
    );

    modport slave (
        input  rom_addr, instr, instr_valid,
        output rom_data, stall, halt, jump, jump_target, branch, branch_eq, branch_off
    );

endinterface

// File: rtl/ifu_next_pc.sv
// Next-PC selection for a RUN cycle: stall/halt hold, jump, taken beq, else sequential.
module ifu_next_pc
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump,
    input  logic [JMP_W-1:0]  jump_target,
    input  logic              branch,
    input  logic              branch_eq,
    input  logic [OFF_W-1:0]  branch_off,
    output logic [ADDR_W-1:0] next_pc_c,
    output logic              retire_c
);

    logic [ADDR_W-1:0] off_ext;

    // Additions truncate to ADDR_W, giving modulo-2^ADDR_W wrap in both directions.
    always_comb begin
        off_ext   = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
        next_pc_c = pc + ADDR_W'(1);
        retire_c  = !stall;
        if (stall || halt) begin
            next_pc_c = pc;
        end else if (jump) begin
            next_pc_c = ADDR_W'(jump_target);
        end else if (branch && branch_eq) begin
            next_pc_c = pc + off_ext;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC-owning fetch front end: run/halt sequencing, ROM addressing, instruction presentation, retire count.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    instr_fetch_unit_if.master        bus,
    output logic [ADDR_W-1:0]         pc,
    output logic                      halted,
    output logic [CNT_W-1:0]          retired
);

    fetch_state_e      state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              halted_q,  halted_d;
    logic              valid_q,   valid_d;

    logic [ADDR_W-1:0] next_pc_c;
    logic              retire_c;
    logic [CNT_W-1:0]  retired_inc;

    ifu_next_pc u_next_pc (
        .pc          (pc_q),
        .stall       (bus.stall),
        .halt        (bus.halt),
        .jump        (bus.jump),
        .jump_target (bus.jump_target),
        .branch      (bus.branch),
        .branch_eq   (bus.branch_eq),
        .branch_off  (bus.branch_off),
        .next_pc_c   (next_pc_c),
        .retire_c    (retire_c)
    );

    assign retired_inc = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= CNT_W'(0);
            halted_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            valid_q   <= valid_d;
        end
    end

    // Decoder controls only matter in RUN; start is only honoured outside RUN.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = RESET_PC;
                    retired_d = CNT_W'(0);
                end
            end
            RUN: begin
                pc_d = next_pc_c;
                if (retire_c) begin
                    retired_d = retired_inc;
                    if (bus.halt) begin
                        state_d = HALTED;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = RESET_PC;
            end
        endcase
        halted_d = (state_d == HALTED);
        valid_d  = (state_d == RUN);
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr       = valid_q ? bus.rom_data : NOP_INSTR;
    assign bus.instr_valid = valid_q;
    assign pc              = pc_q;
    assign halted          = halted_q;
    assign retired         = retired_q;

endmodule
